// File: rtl/audio_sample_packetizer.sv
// Buffers multi-channel L-PCM frames and emits HDMI Audio Sample Packets
// (layout 0 for 2 channels, layout 1 for 8) with IEC 60958 status and parity.
module audio_sample_packetizer #(
  parameter int unsigned CHANNELS               = 2,
  parameter int unsigned SAMPLE_WIDTH           = 24,
  parameter int unsigned FIFO_DEPTH             = 4,
  parameter logic        GRADE                  = 1'b0,
  parameter logic        SAMPLE_WORD_TYPE       = 1'b0,
  parameter logic        COPYRIGHT_NOT_ASSERTED = 1'b1,
  parameter logic [3:0]  SAMPLING_FREQUENCY     = 4'b0000,
  parameter logic [3:0]  WORD_LENGTH            = 4'b1011
) (
  input  logic                                   clk_pixel,
  input  logic                                   reset,
  input  logic                                   audio_sample_valid,
  output logic                                   audio_sample_ready,
  input  logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]  audio_sample_word,
  output logic                                   packet_valid,
  input  logic                                   packet_ready,
  output logic [23:0]                            header,
  output logic [3:0][55:0]                       sub
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  generate
    if (CHANNELS != 2 && CHANNELS != 8) begin : g_bad_channels
      $error("audio_sample_packetizer: CHANNELS must be 2 or 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("audio_sample_packetizer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SAMPLE_WIDTH < 16 || SAMPLE_WIDTH > 24) begin : g_bad_width
      $error("audio_sample_packetizer: SAMPLE_WIDTH must be 16..24");
    end
  endgenerate

  typedef logic [CHANNELS-1:0][23:0] frame_t;

  frame_t              r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr;
  logic [AW-1:0]       r_rd;
  logic [CW-1:0]       r_count;
  logic [7:0]          r_fc;

  frame_t              w_in;
  logic                w_push;
  logic                w_load;
  logic [2:0]          w_n;
  logic [23:0]         w_header;
  logic [3:0][55:0]    w_sub;

  // Channel status bit for a given frame index and 1-based channel number.
  function automatic logic f_cs(input logic [7:0] idx, input logic [3:0] chnum);
    logic b;
    b = 1'b0;
    case (idx)
      8'd0:  b = GRADE;
      8'd1:  b = SAMPLE_WORD_TYPE;
      8'd2:  b = COPYRIGHT_NOT_ASSERTED;
      8'd20: b = chnum[0];
      8'd21: b = chnum[1];
      8'd22: b = chnum[2];
      8'd23: b = chnum[3];
      8'd24: b = SAMPLING_FREQUENCY[0];
      8'd25: b = SAMPLING_FREQUENCY[1];
      8'd26: b = SAMPLING_FREQUENCY[2];
      8'd27: b = SAMPLING_FREQUENCY[3];
      8'd32: b = WORD_LENGTH[0];
      8'd33: b = WORD_LENGTH[1];
      8'd34: b = WORD_LENGTH[2];
      8'd35: b = WORD_LENGTH[3];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Subpacket: two words plus {P,C,U,V} per word, V=U=0, even parity.
  function automatic logic [55:0] f_sub(input logic [23:0] lo, input logic [23:0] hi,
                                        input logic c_lo, input logic c_hi);
    logic p_lo;
    logic p_hi;
    p_lo = (^lo) ^ c_lo;
    p_hi = (^hi) ^ c_hi;
    return {p_hi, c_hi, 2'b00, p_lo, c_lo, 2'b00, hi, lo};
  endfunction

  // (fc + add) mod 192 without widening.
  function automatic logic [7:0] f_wrap(input logic [7:0] fc, input logic [2:0] add);
    if (fc >= 8'd192 - 8'(add)) return fc - (8'd192 - 8'(add));
    else return fc + 8'(add);
  endfunction

  always_comb begin
    w_in = '0;
    for (int c = 0; c < int'(CHANNELS); c++)
      w_in[c] = 24'(audio_sample_word[c]) << (24 - SAMPLE_WIDTH);
  end

  assign w_load             = (!packet_valid || packet_ready) && (r_count != '0);
  assign audio_sample_ready = (32'(r_count) != FIFO_DEPTH) || w_load;
  assign w_push             = audio_sample_valid && audio_sample_ready;

  always_comb begin
    w_n = 3'd1;
    if (CHANNELS == 2) w_n = (32'(r_count) >= 32'd4) ? 3'd4 : 3'(r_count);
  end

  generate
    if (CHANNELS == 8) begin : g_layout1
      frame_t w_fr;
      always_comb begin
        w_header        = 24'd2;
        w_sub           = '0;
        w_header[11:8]  = 4'hF;
        w_header[12]    = 1'b1;
        w_header[20]    = (r_fc == 8'd0);
        w_fr            = r_mem[r_rd];
        for (int k = 0; k < 4; k++)
          w_sub[k] = f_sub(w_fr[2*k], w_fr[2*k+1],
                           f_cs(r_fc, 4'(2*k+1)), f_cs(r_fc, 4'(2*k+2)));
      end
    end else begin : g_layout0
      frame_t w_fr;
      logic [7:0] w_idx;
      always_comb begin
        w_header = 24'd2;
        w_sub    = '0;
        w_fr     = '0;
        w_idx    = '0;
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < w_n) begin
            w_idx           = f_wrap(r_fc, 3'(i));
            w_fr            = r_mem[r_rd + AW'(i)];
            w_header[8+i]   = 1'b1;
            w_header[20+i]  = (w_idx == 8'd0);
            w_sub[i]        = f_sub(w_fr[0], w_fr[1], f_cs(w_idx, 4'd1), f_cs(w_idx, 4'd2));
          end
        end
      end
    end
  endgenerate

  // Frame storage; reset only needs to clear the pointers.
  always_ff @(posedge clk_pixel) begin
    if (w_push) r_mem[r_wr] <= w_in;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      r_fc         <= '0;
      packet_valid <= 1'b0;
      header       <= '0;
      sub          <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_load) begin
        r_rd         <= r_rd + AW'(w_n);
        r_fc         <= f_wrap(r_fc, w_n);
        packet_valid <= 1'b1;
        header       <= w_header;
        sub          <= w_sub;
      end else if (packet_ready) begin
        packet_valid <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - (w_load ? CW'(w_n) : CW'(0));
    end
  end

endmodule

// File: tb/tb_audio_sample_packetizer.sv
// Directed bench for audio_sample_packetizer: 2-channel and 8-channel instances.
module tb_audio_sample_packetizer;
  logic clk;
  logic r2, v2, rdy2, pv2, pr2;
  logic [1:0][23:0] w2;
  logic [23:0] hdr2;
  logic [3:0][55:0] sub2;
  logic r8, v8, rdy8, pv8, pr8;
  logic [7:0][23:0] w8;
  logic [23:0] hdr8;
  logic [3:0][55:0] sub8;

  int n_checks = 0;
  int n_errors = 0;

  audio_sample_packetizer #(.CHANNELS(2)) dut2 (
    .clk_pixel(clk), .reset(r2), .audio_sample_valid(v2), .audio_sample_ready(rdy2),
    .audio_sample_word(w2), .packet_valid(pv2), .packet_ready(pr2),
    .header(hdr2), .sub(sub2));

  audio_sample_packetizer #(.CHANNELS(8)) dut8 (
    .clk_pixel(clk), .reset(r8), .audio_sample_valid(v8), .audio_sample_ready(rdy8),
    .audio_sample_word(w8), .packet_valid(pv8), .packet_ready(pr8),
    .header(hdr8), .sub(sub8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset2();
    r2 = 1'b1; v2 = 1'b0; pr2 = 1'b0; w2 = '0;
    tick();
    r2 = 1'b0;
  endtask

  task automatic push2(input logic [23:0] l, input logic [23:0] r);
    v2 = 1'b1; w2[0] = l; w2[1] = r;
    tick();
    v2 = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_c3;
    logic [3:0] exp_c8;
    exp_c3 = 4'b0011;
    exp_c8 = 4'b1000;
    r8 = 1'b1; v8 = 1'b0; pr8 = 1'b0; w8 = '0;

    // Test 1: reset state and a basic packet
    r2 = 1'b1; v2 = 1'b0; pr2 = 1'b0; w2 = '0;
    tick();
    check("rst_ready", 64'(rdy2), 64'd1);
    check("rst_valid", 64'(pv2), 64'd0);
    check("rst_header", 64'(hdr2), 64'd0);
    check("rst_sub0", 64'(sub2[0]), 64'd0);
    check("rst_sub3", 64'(sub2[3]), 64'd0);
    r2 = 1'b0;
    pr2 = 1'b1;
    push2(24'h123456, 24'hABCDEF);
    check("t1_valid_early", 64'(pv2), 64'd0);
    tick();
    check("t1_valid", 64'(pv2), 64'd1);
    check("t1_header", 64'(hdr2), 64'h100102);
    check("t1_sub0", 64'(sub2[0]), 64'h88ABCDEF123456);
    check("t1_sub1", 64'(sub2[1]), 64'd0);
    check("t1_sub2", 64'(sub2[2]), 64'd0);
    check("t1_sub3", 64'(sub2[3]), 64'd0);
    tick();
    check("t1_valid_clear", 64'(pv2), 64'd0);

    // Test 2: backpressure with a full FIFO
    reset2();
    for (int j = 0; j < 5; j++) push2(24'h100 + 24'(j), 24'h200 + 24'(j));
    v2 = 1'b1; w2[0] = 24'h105; w2[1] = 24'h205;
    check("t2_ready_full", 64'(rdy2), 64'd0);
    tick();
    v2 = 1'b0;
    check("t2_hold_valid", 64'(pv2), 64'd1);
    check("t2_hold_header", 64'(hdr2), 64'h100102);
    check("t2_hold_sub0", 64'(sub2[0]), 64'h88000200000100);
    tick();
    check("t2_hold_sub0_again", 64'(sub2[0]), 64'h88000200000100);
    pr2 = 1'b1;
    tick();
    check("t2_hdr4", 64'(hdr2), 64'h000F02);
    check("t2_sub0", 64'(sub2[0]), 64'h00000201000101);
    check("t2_sub1", 64'(sub2[1]), 64'hCC000202000102);
    check("t2_sub3", 64'(sub2[3]), 64'h00000204000104);
    check("t2_ready_after", 64'(rdy2), 64'd1);
    tick();
    check("t2_no_extra", 64'(pv2), 64'd0);

    // Test 3: frame counter wrap inside a 4-sample packet
    reset2();
    pr2 = 1'b1;
    for (int j = 0; j < 189; j++) push2(24'd0, 24'd0);
    tick(); tick(); tick();
    check("t3_idle", 64'(pv2), 64'd0);
    pr2 = 1'b0;
    for (int j = 0; j < 5; j++) push2(24'h000001, 24'h000003);
    pr2 = 1'b1;
    tick();
    check("t3_wrap_hdr", 64'(hdr2), 64'h400F02);
    check("t3_wrap_sub2", 64'(sub2[2]), 64'h08000003000001);
    check("t3_wrap_sub3", 64'(sub2[3]), 64'h08000003000001);
    tick();
    check("t3_drained", 64'(pv2), 64'd0);
    push2(24'h000001, 24'h000003);
    tick();
    check("t3_fc2_hdr", 64'(hdr2), 64'h000102);
    check("t3_fc2_sub0", 64'(sub2[0]), 64'hC4000003000001);

    // Test 5: parity of a single set bit
    reset2();
    pr2 = 1'b1;
    push2(24'h000001, 24'h000000);
    tick();
    check("t5_hdr", 64'(hdr2), 64'h100102);
    check("t5_sub0", 64'(sub2[0]), 64'h08000000000001);

    // Test 6: reset mid-operation
    reset2();
    for (int j = 0; j < 4; j++) push2(24'h10 + 24'(j), 24'h20 + 24'(j));
    check("t6_pre_valid", 64'(pv2), 64'd1);
    r2 = 1'b1;
    #2;
    check("t6_rst_valid", 64'(pv2), 64'd0);
    check("t6_rst_ready", 64'(rdy2), 64'd1);
    check("t6_rst_header", 64'(hdr2), 64'd0);
    tick();
    r2 = 1'b0;
    pr2 = 1'b1;
    push2(24'h000005, 24'h000000);
    tick();
    check("t6_hdr", 64'(hdr2), 64'h100102);
    check("t6_sub0", 64'(sub2[0]), 64'h00000000000005);
    tick();
    check("t6_no_stale", 64'(pv2), 64'd0);

    // Test 4: 8-channel layout over 24 frames
    tick();
    r8 = 1'b0;
    pr8 = 1'b1;
    for (int c = 0; c < 8; c++) w8[c] = 24'(c + 1);
    for (int j = 0; j <= 24; j++) begin
      v8 = (j < 24);
      tick();
      if (j >= 1) begin
        check($sformatf("t4_valid_f%0d", j - 1), 64'(pv8), 64'd1);
        check($sformatf("t4_hdr_f%0d", j - 1), 64'(hdr8), (j == 1) ? 64'h101F02 : 64'h001F02);
        if (j == 1) check("t4_sub0_f0", 64'(sub8[0]), 64'h88000002000001);
        if (j == 21) check("t4_sub1_f20", 64'(sub8[1]), 64'h8C000004000003);
        if (j >= 21) begin
          check($sformatf("t4_c3_f%0d", j - 1), 64'(sub8[1][50]), 64'(exp_c3[j-21]));
          check($sformatf("t4_c8_f%0d", j - 1), 64'(sub8[3][54]), 64'(exp_c8[j-21]));
        end
      end
    end
    v8 = 1'b0;
    tick();
    check("t4_done", 64'(pv8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
